// File: rtl/cache_controller_if.sv
// Bus bundle between the cache read controller and its CPU, cache-storage and main-memory neighbours.
// The controller uses the slave modport; the surrounding system uses master.
interface cache_controller_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              cpuReq;
    logic [ADDR_W-1:0] cpuAddr;
    logic [DATA_W-1:0] cpuData;
    logic              cpuDone;
    logic              busy;
    logic              checkHit;
    logic              readData;
    logic              writeData;
    logic [ADDR_W-1:0] cacheAddr;
    logic [DATA_W-1:0] cacheWr0;
    logic [DATA_W-1:0] cacheWr1;
    logic [DATA_W-1:0] cacheWr2;
    logic [DATA_W-1:0] cacheWr3;
    logic              hit;
    logic [DATA_W-1:0] cacheDataOut;
    logic              memRead;
    logic [ADDR_W-1:0] memAddr;
    logic              memReady;
    logic [DATA_W-1:0] memData0;
    logic [DATA_W-1:0] memData1;
    logic [DATA_W-1:0] memData2;
    logic [DATA_W-1:0] memData3;
    logic [CNT_W-1:0]  hitCount;
    logic [CNT_W-1:0]  missCount;

    modport slave (
        input  cpuReq, cpuAddr, hit, cacheDataOut, memReady,
               memData0, memData1, memData2, memData3,
        output cpuData, cpuDone, busy, checkHit, readData, writeData, cacheAddr,
               cacheWr0, cacheWr1, cacheWr2, cacheWr3, memRead, memAddr,
               hitCount, missCount
    );

    modport master (
        output cpuReq, cpuAddr, hit, cacheDataOut, memReady,
               memData0, memData1, memData2, memData3,
        input  cpuData, cpuDone, busy, checkHit, readData, writeData, cacheAddr,
               cacheWr0, cacheWr1, cacheWr2, cacheWr3, memRead, memAddr,
               hitCount, missCount
    );
endinterface

// File: rtl/cache_controller.sv
// Read-side controller for a direct-mapped cache: hit check, block refill from main memory,
// word return to the CPU and saturating hit/miss statistics.
module cache_controller #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    cache_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        EVAL    = 3'd2,
        MEM_REQ = 3'd3,
        FILL    = 3'd4,
        READ    = 3'd5,
        RESP    = 3'd6
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] fill0_r, fill1_r, fill2_r, fill3_r;
    logic [DATA_W-1:0] cpu_data_r;
    logic              cpu_done_r;
    logic              check_hit_r, read_data_r, write_data_r, mem_read_r, busy_r;
    logic [CNT_W-1:0]  hit_count_r, miss_count_r;

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        unique case (state_r)
            IDLE: begin
                if (bus.cpuReq) begin
                    next_state_s = CHECK;
                end else begin
                    next_state_s = IDLE;
                end
            end
            CHECK:   next_state_s = EVAL;
            EVAL: begin
                if (bus.hit) begin
                    next_state_s = READ;
                end else begin
                    next_state_s = MEM_REQ;
                end
            end
            MEM_REQ: begin
                if (bus.memReady) begin
                    next_state_s = FILL;
                end else begin
                    next_state_s = MEM_REQ;
                end
            end
            FILL:    next_state_s = READ;
            READ:    next_state_s = RESP;
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Moore commands registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_hit_r  <= 1'b0;
            read_data_r  <= 1'b0;
            write_data_r <= 1'b0;
            mem_read_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            check_hit_r  <= (next_state_s == CHECK);
            read_data_r  <= (next_state_s == READ);
            write_data_r <= (next_state_s == FILL);
            mem_read_r   <= (next_state_s == MEM_REQ);
            busy_r       <= (next_state_s != IDLE);
        end
    end

    // Request address latch, refill capture and CPU response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= {ADDR_W{1'b0}};
            fill0_r    <= {DATA_W{1'b0}};
            fill1_r    <= {DATA_W{1'b0}};
            fill2_r    <= {DATA_W{1'b0}};
            fill3_r    <= {DATA_W{1'b0}};
            cpu_data_r <= {DATA_W{1'b0}};
            cpu_done_r <= 1'b0;
        end else begin
            if ((state_r == IDLE) && bus.cpuReq) begin
                addr_r <= bus.cpuAddr;
            end
            if ((state_r == MEM_REQ) && bus.memReady) begin
                fill0_r <= bus.memData0;
                fill1_r <= bus.memData1;
                fill2_r <= bus.memData2;
                fill3_r <= bus.memData3;
            end
            if (state_r == RESP) begin
                cpu_data_r <= bus.cacheDataOut;
            end
            cpu_done_r <= (state_r == RESP);
        end
    end

    // Hit/miss statistics; both stop at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_r  <= {CNT_W{1'b0}};
            miss_count_r <= {CNT_W{1'b0}};
        end else if (state_r == EVAL) begin
            if (bus.hit) begin
                if (hit_count_r != {CNT_W{1'b1}}) begin
                    hit_count_r <= hit_count_r + CNT_W'(1);
                end
            end else begin
                if (miss_count_r != {CNT_W{1'b1}}) begin
                    miss_count_r <= miss_count_r + CNT_W'(1);
                end
            end
        end
    end

    assign bus.cpuData   = cpu_data_r;
    assign bus.cpuDone   = cpu_done_r;
    assign bus.busy      = busy_r;
    assign bus.checkHit  = check_hit_r;
    assign bus.readData  = read_data_r;
    assign bus.writeData = write_data_r;
    assign bus.memRead   = mem_read_r;
    assign bus.cacheAddr = addr_r;
    assign bus.memAddr   = {addr_r[ADDR_W-1:2], 2'b00};
    assign bus.cacheWr0  = fill0_r;
    assign bus.cacheWr1  = fill1_r;
    assign bus.cacheWr2  = fill2_r;
    assign bus.cacheWr3  = fill3_r;
    assign bus.hitCount  = hit_count_r;
    assign bus.missCount = miss_count_r;
endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: behavioural cache storage and main memory around the DUT, with a
// scoreboard queue checked by a monitor on every cpuDone. A CNT_W=2 copy shadows the same inputs.
module tb_cache_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cache_controller_if #(.ADDR_W(15), .DATA_W(32), .CNT_W(16)) bus ();
    cache_controller_if #(.ADDR_W(15), .DATA_W(32), .CNT_W(2))  bus2 ();

    cache_controller #(.ADDR_W(15), .DATA_W(32), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    cache_controller #(.ADDR_W(15), .DATA_W(32), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    logic [31:0] md [4];
    assign bus.memData0 = md[0];
    assign bus.memData1 = md[1];
    assign bus.memData2 = md[2];
    assign bus.memData3 = md[3];
    assign bus2.memData0 = md[0];
    assign bus2.memData1 = md[1];
    assign bus2.memData2 = md[2];
    assign bus2.memData3 = md[3];
    assign bus2.cpuReq       = bus.cpuReq;
    assign bus2.cpuAddr      = bus.cpuAddr;
    assign bus2.hit          = bus.hit;
    assign bus2.cacheDataOut = bus.cacheDataOut;
    assign bus2.memReady     = bus.memReady;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment: cache storage answers one cycle after checkHit/readData; memory answers on a chosen MEM_REQ cycle.
    logic        cvalid [1024];
    logic [2:0]  ctag   [1024];
    logic [31:0] cdata  [1024][4];
    logic        prev_check, prev_read;
    int          mem_cyc, mem_ready_at, memread_cycles, wr_pulses;
    logic [14:0] seen_mem_addr;
    logic [31:0] wr_seen [4];
    logic [9:0]  e_idx;

    always @(negedge clk) begin
        e_idx = bus.cacheAddr[11:2];
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) cvalid[i] = 1'b0;
            prev_check = 1'b0;
            prev_read = 1'b0;
            mem_cyc = 0;
            bus.memReady = 1'b0;
            bus.hit = 1'b0;
            bus.cacheDataOut = 32'h0;
        end else begin
            bus.hit = prev_check && cvalid[e_idx] && (ctag[e_idx] == bus.cacheAddr[14:12]);
            prev_check = bus.checkHit;
            if (prev_read) bus.cacheDataOut = cdata[e_idx][bus.cacheAddr[1:0]];
            prev_read = bus.readData;
            if (bus.writeData) begin
                wr_pulses++;
                wr_seen[0] = bus.cacheWr0; wr_seen[1] = bus.cacheWr1;
                wr_seen[2] = bus.cacheWr2; wr_seen[3] = bus.cacheWr3;
                cvalid[e_idx] = 1'b1;
                ctag[e_idx] = bus.cacheAddr[14:12];
                for (int k = 0; k < 4; k++) cdata[e_idx][k] = wr_seen[k];
            end
            if (bus.memRead) begin
                mem_cyc++;
                memread_cycles++;
                seen_mem_addr = bus.memAddr;
                bus.memReady = (mem_cyc == mem_ready_at);
            end else begin
                mem_cyc = 0;
                bus.memReady = 1'b0;
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        int          done_cyc;
        int          hits;
        int          misses;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.cpuDone) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("cpuData", bus.cpuData, mon_e.data);
                chk("done_cycle", cyc, mon_e.done_cyc);
                chk("hitCount", bus.hitCount, mon_e.hits);
                chk("missCount", bus.missCount, mon_e.misses);
            end
        end
    end

    task automatic set_mem(input logic [31:0] base, input int ready_at);
        for (int i = 0; i < 4; i++) md[i] = base + 32'(i);
        mem_ready_at = ready_at;
        memread_cycles = 0;
        wr_pulses = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            chk("completion_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    task automatic do_req(input logic [14:0] a, input logic [31:0] d, input int lat, input int h, input int m);
        int n;
        n = 0;
        while (bus.busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        sb_q.push_back('{d, cyc + 1 + lat, h, m});
        bus.cpuReq = 1'b1;
        bus.cpuAddr = a;
        @(negedge clk);
        bus.cpuReq = 1'b0;
        drain();
        @(negedge clk);
    endtask

    initial begin
        bus.cpuReq = 1'b0;
        bus.cpuAddr = 15'h0;
        set_mem(32'hA0, 1);
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cpuDone", bus.cpuDone, 0);
        chk("rst_cpuData", bus.cpuData, 0);
        chk("rst_cmds", {bus.checkHit, bus.readData, bus.writeData, bus.memRead}, 0);
        chk("rst_counts", {bus.hitCount, bus.missCount}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, memory ready on the third MEM_REQ cycle.
        set_mem(32'hA0, 3);
        do_req(15'h1005, 32'hA1, 8, 0, 1);
        chk("miss_memAddr", seen_mem_addr, 15'h1004);
        chk("miss_memread_cycles", memread_cycles, 3);
        chk("miss_wr_pulses", wr_pulses, 1);
        for (int i = 0; i < 4; i++) chk("miss_fill_word", wr_seen[i], 32'hA0 + 32'(i));

        // Hit in the same block.
        set_mem(32'hA0, 1);
        do_req(15'h1007, 32'hA3, 4, 1, 1);
        chk("hit_no_memread", memread_cycles, 0);
        chk("hit_no_write", wr_pulses, 0);

        // Conflicting tag at the same index, then the original address misses again.
        set_mem(32'hB0, 1);
        do_req(15'h5005, 32'hB1, 6, 1, 2);
        chk("conflict_memAddr", seen_mem_addr, 15'h5004);
        set_mem(32'hA0, 2);
        do_req(15'h1005, 32'hA1, 7, 1, 3);

        // cpuReq held through busy with a changing address; back-to-back accept in the done cycle.
        sb_q.push_back('{32'hA2, cyc + 5, 2, 3});
        bus.cpuReq = 1'b1;
        bus.cpuAddr = 15'h1006;
        @(negedge clk) bus.cpuAddr = 15'h5006;
        @(negedge clk) bus.cpuAddr = 15'h2222;
        @(negedge clk) bus.cpuAddr = 15'h0001;
        @(negedge clk) bus.cpuAddr = 15'h0002;
        @(negedge clk);
        chk("b2b_done_seen", bus.cpuDone, 1);
        bus.cpuAddr = 15'h1004;
        sb_q.push_back('{32'hA0, cyc + 5, 3, 3});
        @(negedge clk) bus.cpuReq = 1'b0;
        drain();
        chk("sat_pre_reset", bus2.hitCount, 3);
        @(negedge clk);

        // Reset while waiting in MEM_REQ.
        set_mem(32'hC0, 100);
        bus.cpuReq = 1'b1;
        bus.cpuAddr = 15'h2000;
        @(negedge clk) bus.cpuReq = 1'b0;
        for (int n = 0; n < 10 && !bus.memRead; n++) @(negedge clk);
        chk("pre_rst_memRead", bus.memRead, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_memRead", bus.memRead, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_counts", {bus.hitCount, bus.missCount}, 0);
        chk("async_cpuDone", bus.cpuDone, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);

        // Cold miss after reset, then five hits; the CNT_W=2 copy saturates at 3.
        set_mem(32'hA0, 1);
        do_req(15'h1005, 32'hA1, 6, 0, 1);
        chk("post_rst_memread", memread_cycles, 1);
        for (int k = 1; k <= 5; k++) begin
            do_req(15'h1004 + 15'(k % 4), 32'hA0 + 32'(k % 4), 4, k, 1);
            chk("sat_hitCount", bus2.hitCount, (k < 3) ? k : 3);
        end

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end
endmodule
